// File: rtl/iir8_coeff_ctrl.sv
// iir8_coeff_ctrl: shadow/active coefficient bank, atomic apply on frame sync, settle timer gating out_valid.
// Optional active-bank readback is enabled by defining IIR8_COEFF_READBACK_EN.
module iir8_coeff_ctrl #(
    parameter int          NSECT         = 4,
    parameter int          ADDRBITS      = 4,
    parameter int          SETTLE_CYCLES = 8,
    parameter logic [11:0] DEFAULT_COEF  = 12'h800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDRBITS-1:0]   wr_addr,
    input  logic [11:0]           wr_data,
    output logic                  wr_err,
    input  logic                  commit,
    input  logic                  sync,
    output logic [12*NSECT-1:0]   mult_val_out,
    output logic                  coef_update,
    output logic                  out_valid,
    output logic                  busy,
    input  logic [ADDRBITS-1:0]   rd_addr,
    output logic [11:0]           rd_data
);
    typedef enum logic [1:0] {IDLE, PENDING, SETTLE} state_t;
    localparam logic [7:0]        CNT_INIT = 8'(SETTLE_CYCLES - 1);
    localparam logic [ADDRBITS:0] NS       = (ADDRBITS + 1)'(NSECT);
    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic        pend, pend_d, ov_d, apply, wr_bad;
    logic [11:0] shadow [NSECT];
    logic [11:0] active [NSECT];
    assign wr_bad = {1'b0, wr_addr} >= NS;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pend_d  = pend;
        ov_d    = out_valid;
        apply   = 1'b0;
        case (state)
            IDLE:    state_d = commit ? PENDING : IDLE;
            PENDING: if (sync) begin
                apply   = 1'b1;
                state_d = SETTLE;
                cnt_d   = CNT_INIT;
                ov_d    = 1'b0;
            end
            SETTLE:  if (cnt == 8'd0) begin
                // a commit arriving while settling is held and served once the pipeline is flushed
                state_d = (pend || commit) ? PENDING : IDLE;
                ov_d    = !(pend || commit);
                pend_d  = 1'b0;
            end else begin
                cnt_d  = cnt - 8'd1;
                pend_d = pend || commit;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SETTLE;
            cnt         <= CNT_INIT;
            pend        <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b1;
            coef_update <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pend        <= pend_d;
            out_valid   <= ov_d;
            busy        <= state_d != IDLE;
            coef_update <= apply;
            wr_err      <= wr_en && wr_bad;
        end
    end
    // the copy reads the pre-edge shadow, so a same-cycle write is excluded from the applied set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSECT; s++) begin
                shadow[s] <= DEFAULT_COEF;
                active[s] <= DEFAULT_COEF;
            end
        end else begin
            for (int s = 0; s < NSECT; s++) begin
                if (wr_en && wr_addr == ADDRBITS'(s)) shadow[s] <= wr_data;
                if (apply) active[s] <= shadow[s];
            end
        end
    end
    for (genvar g = 0; g < NSECT; g++) begin : g_out
        assign mult_val_out[12*g +: 12] = active[g];
    end
`ifdef IIR8_COEFF_READBACK_EN
    logic [11:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        for (int s = 0; s < NSECT; s++) if (rd_addr == ADDRBITS'(s)) rd_mux = active[s];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else rd_data <= rd_mux;
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = '0;
`endif
endmodule

// File: tb/tb_iir8_coeff_ctrl.sv
// tb_iir8_coeff_ctrl: directed stimulus, cycle-level behavioural model compared every cycle, plus literal checks.
module tb_iir8_coeff_ctrl;
    localparam int NSECT = 4;
    localparam int AB    = 4;
    localparam int SC    = 8;
    localparam logic [11:0] DEF = 12'h800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0, commit = 1'b0, sync = 1'b0;
    logic [AB-1:0] wr_addr = '0, rd_addr = '0;
    logic [11:0] wr_data = '0;
    logic wr_err, coef_update, out_valid, busy;
    logic [12*NSECT-1:0] mult_val_out;
    logic [11:0] rd_data;
    int checks = 0, errors = 0;

    iir8_coeff_ctrl #(.NSECT(NSECT), .ADDRBITS(AB), .SETTLE_CYCLES(SC), .DEFAULT_COEF(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .commit(commit), .sync(sync), .mult_val_out(mult_val_out),
        .coef_update(coef_update), .out_valid(out_valid), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // model: shadow/active banks, "waiting for sync" flag, remaining settle edges
    logic [11:0] m_sh [NSECT];
    logic [11:0] m_act [NSECT];
    logic [11:0] old_sh [NSECT];
    logic m_wait, m_queued, m_ov, m_upd, m_err;
    logic [11:0] m_rd;
    int m_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NSECT; s++) begin m_sh[s] = DEF; m_act[s] = DEF; end
            m_wait = 0; m_queued = 0; m_left = SC; m_ov = 0; m_upd = 0; m_err = 0; m_rd = 0;
        end else begin
            old_sh = m_sh;
            m_rd = 12'h000;
            for (int s = 0; s < NSECT; s++) if (int'(rd_addr) == s) m_rd = m_act[s];
            m_err = wr_en && int'(wr_addr) >= NSECT;
            for (int s = 0; s < NSECT; s++) if (wr_en && int'(wr_addr) == s) m_sh[s] = wr_data;
            m_upd = 0;
            if (m_left > 0) begin
                m_queued = m_queued | commit;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_queued) m_wait = 1; else m_ov = 1;
                    m_queued = 0;
                end
            end else if (m_wait) begin
                if (sync) begin
                    m_act = old_sh; m_upd = 1; m_ov = 0; m_left = SC; m_wait = 0;
                end
            end else if (commit) m_wait = 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [12*NSECT-1:0] m_mult;
    always_comb for (int s = 0; s < NSECT; s++) m_mult[12*s +: 12] = m_act[s];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("busy", 64'(busy), 64'(m_wait || m_left > 0));
            chk("coef_update", 64'(coef_update), 64'(m_upd));
            chk("wr_err", 64'(wr_err), 64'(m_err));
            chk("mult_val_out", 64'(mult_val_out), 64'(m_mult));
`ifdef IIR8_COEFF_READBACK_EN
            chk("rd_data", 64'(rd_data), 64'(m_rd));
`else
            chk("rd_data", 64'(rd_data), 64'h0);
`endif
        end
    end

    task automatic cyc(input logic we, input logic [AB-1:0] wa, input logic [11:0] wd,
                       input logic cm, input logic sy);
        wr_en = we; wr_addr = wa; wr_data = wd; commit = cm; sync = sy;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'h0);
        chk("rst busy", 64'(busy), 64'h1);
        chk("rst coef_update", 64'(coef_update), 64'h0);
        chk("rst wr_err", 64'(wr_err), 64'h0);
        chk("rst rd_data", 64'(rd_data), 64'h0);
        chk("rst mult", 64'(mult_val_out), 64'({4{12'h800}}));
        rst_n = 1'b1;
        idle(7);
        chk("post-rst ov low 7", 64'(out_valid), 64'h0);
        idle(1);
        chk("post-rst ov high 8", 64'(out_valid), 64'h1);
        chk("post-rst busy", 64'(busy), 64'h0);
        // write + commit, sync five cycles later
        cyc(1, 0, 12'h3FF, 0, 0);
        cyc(1, 3, 12'hC00, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(4);
        cyc(0, 0, 0, 0, 1);
        chk("apply1 update", 64'(coef_update), 64'h1);
        chk("apply1 mult", 64'(mult_val_out), 64'({12'hC00, 12'h800, 12'h800, 12'h3FF}));
        chk("apply1 ov low", 64'(out_valid), 64'h0);
        idle(7);
        chk("apply1 ov N+8", 64'(out_valid), 64'h0);
        idle(1);
        chk("apply1 ov N+9", 64'(out_valid), 64'h1);
        // commit+sync together in IDLE: sync not used
        cyc(1, 1, 12'h100, 0, 0);
        cyc(0, 0, 0, 1, 1);
        idle(20);
        chk("atomic busy", 64'(busy), 64'h1);
        chk("atomic held", 64'(mult_val_out), 64'({12'hC00, 12'h800, 12'h800, 12'h3FF}));
        // apply with a same-cycle write to s2
        cyc(1, 2, 12'h222, 0, 1);
        chk("apply2 mult", 64'(mult_val_out), 64'({12'hC00, 12'h800, 12'h100, 12'h3FF}));
        idle(2);
        cyc(0, 0, 0, 1, 0);
        idle(4);
        chk("settle-commit ov N+8", 64'(out_valid), 64'h0);
        idle(1);
        chk("settle-commit ov N+9", 64'(out_valid), 64'h0);
        chk("settle-commit busy", 64'(busy), 64'h1);
        idle(3);
        cyc(0, 0, 0, 0, 1);
        chk("apply3 mult", 64'(mult_val_out), 64'({12'hC00, 12'h222, 12'h100, 12'h3FF}));
        rd_addr = 0;
        idle(1);
`ifdef IIR8_COEFF_READBACK_EN
        chk("readback s0", 64'(rd_data), 64'h3FF);
`endif
        rd_addr = 5;
        idle(10);
        // bad address and positive boundary value
        cyc(1, 4'(NSECT), 12'h555, 0, 0);
        chk("wr_err pulse", 64'(wr_err), 64'h1);
        cyc(1, 0, 12'h7FF, 0, 0);
        chk("wr_err clear", 64'(wr_err), 64'h0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("apply4 mult", 64'(mult_val_out), 64'({12'hC00, 12'h222, 12'h100, 12'h7FF}));
        idle(10);
        // reset while pending discards the commit and shadow contents
        cyc(1, 0, 12'h001, 1, 0);
        rst_n = 1'b0;
        idle(2);
        chk("mid-rst mult", 64'(mult_val_out), 64'({4{12'h800}}));
        rst_n = 1'b1;
        idle(8);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("post-rst apply mult", 64'(mult_val_out), 64'({4{12'h800}}));
        chk("post-rst apply update", 64'(coef_update), 64'h1);
        idle(12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iir8_coeff_ctrl.md
Name: iir8_coeff_ctrl

Overview:
Coefficient configuration and update sequencer for a bank of NSECT 8-fold IIR FIR sections, each driven by a 12-bit signed mult_val (2·Re(zero)·1024).
- Writes land in a shadow bank; a commit is applied to all sections atomically on the next frame-sync strobe.
- After an apply, the pipeline is flushed by a settle counter, and out_valid is deasserted until the filter output reflects the new coefficients.
- Sits between the control register interface and the iir8 datapath.

Parameters:
NSECT, 4, number of FIR sections controlled (1..16)
ADDRBITS, 4, width of wr_addr/rd_addr; 2^ADDRBITS >= NSECT
SETTLE_CYCLES, 8, cycles out_valid is held low after an apply (>=1, <=255)
DEFAULT_COEF, 12'h800, reset value of every shadow and active coefficient (-2.0)

Ports:
clk  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  shadow write strobe
wr_addr  in  ADDRBITS  section index for write
wr_data  in  12  signed coefficient (Q2.10)
wr_err  out  1  1-cycle pulse: write rejected (wr_addr >= NSECT)
commit  in  1  request atomic apply of shadow bank
sync  in  1  frame-boundary strobe from datapath
mult_val_out  out  12*NSECT  active coefficients; section s at [12*s +: 12]
coef_update  out  1  1-cycle pulse, the cycle active bank changes
out_valid  out  1  datapath output trustworthy
busy  out  1  high in PENDING or SETTLE
rd_addr  in  ADDRBITS  readback index (optional feature)
rd_data  out  12  readback data (optional feature)

Behaviour:
- Reset (rst_n low, async):
  - All shadow/active coefficients = DEFAULT_COEF.
  - State = SETTLE, cnt = SETTLE_CYCLES-1.
  - out_valid = 0, busy = 1, coef_update = 0, wr_err = 0, rd_data = 0.
- Writes:
  - wr_en with wr_addr < NSECT: shadow[wr_addr] <= wr_data at the edge. Accepted in every state, no backpressure.
  - wr_addr >= NSECT: no write; wr_err high the next cycle for 1 cycle.
  - The active bank is never written directly.
- States:
  - IDLE: commit -> PENDING. sync ignored.
  - PENDING: sync -> apply (see below), then SETTLE. commit ignored (already pending).
  - SETTLE: each cycle cnt decrements. Leaving SETTLE at the edge where cnt==0:
    - commit seen during SETTLE or in that cycle -> PENDING, out_valid stays 0.
    - otherwise -> IDLE, out_valid <= 1.
  - commit during SETTLE sets a pending flag; it does not restart cnt.
- Apply (sync sampled high in PENDING, cycle N), at the edge ending cycle N:
  - active <= shadow (all sections together).
  - coef_update <= 1 for cycle N+1 only.
  - out_valid <= 0, cnt <= SETTLE_CYCLES-1, state <= SETTLE.
- Timing:
  - out_valid is low for exactly cycles N+1..N+SETTLE_CYCLES and high at N+SETTLE_CYCLES+1 (absent further commits).
  - After rst_n deasserts, out_valid rises after SETTLE_CYCLES clock edges.
- Simultaneous events:
  - commit+sync in IDLE: enter PENDING only; the sync is not used; apply occurs on the next sync.
  - wr_en in the apply cycle N: the write lands in shadow after the copy and is NOT in the applied set.
  - A write in the commit cycle IS included (it precedes the apply).
- Widths and outputs:
  - Coefficients pass unmodified; the 12-bit signed range -2048..2047 is the legal range, with no clamping.
  - mult_val_out, out_valid, busy and coef_update are registered outputs.
- Reset mid-SETTLE or mid-PENDING: the pending commit is discarded and the shadow contents are lost to DEFAULT_COEF.

Optional Feature:
IIR8_COEFF_READBACK_EN
- Defined: rd_data <= active[rd_addr] with 1-cycle registered latency; rd_addr >= NSECT returns 12'h000.
- Undefined: rd_data is constant 0, rd_addr is unused, and no read mux is synthesized.
- The shadow bank is never readable in either build.

Test Plan:
- Reset: release rst_n, SETTLE_CYCLES=8 -> out_valid 0 for 8 edges then 1; all mult_val_out = 12'h800; busy falls with out_valid.
- Write+commit: write s0=12'h3FF, s3=12'hC00; commit; sync 5 cycles later (N) -> coef_update pulse at N+1; mult_val_out changes at N+1 with others still 12'h800; out_valid low N+1..N+8, high at N+9.
- Atomicity: write s1=12'h100; commit+sync same cycle; no further sync for 20 cycles -> active unchanged, busy=1; next sync applies 12'h100.
- Apply-cycle write: write s2=12'h222 in cycle N -> active s2 keeps its old value; a second commit+sync applies 12'h222.
- Bad address: wr_addr=NSECT, data 12'h555 -> wr_err 1-cycle pulse; no shadow change after the next apply.
- Commit in SETTLE: commit at N+3 -> after cnt expires goes to PENDING, out_valid stays 0 until the next sync+8 cycles; readback (feature on) rd_addr=0 returns 12'h3FF one cycle later.
